// File: rtl/serial_cs_adder_ctrl.sv
// Sequencing controller that performs a 2N-bit addition through one shared
// 2-bit carry-select adder slice, LSB slice first, holding each slice SETTLE cycles.
module serial_cs_adder_ctrl #(
    parameter int N      = 4,
    parameter int SETTLE = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    input  logic           cin,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] sum,
    output logic           cout,
    output logic [1:0]     add_a,
    output logic [1:0]     add_b,
    output logic           add_cin,
    input  logic [1:0]     add_s,
    input  logic           add_cout
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SLICE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]     state;
    logic [2*N-1:0] op_a;
    logic [2*N-1:0] op_b;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic           carry;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  cnt;
    logic           last_cnt;
    logic           last_idx;

    assign last_cnt = (cnt == CW'(SETTLE - 1));
    assign last_idx = (idx == IW'(N - 1));

    // Accumulator with the current slice result merged in, so the final
    // capture can load sum in the same edge without a partial update.
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        acc_next = acc;
        acc_next[{idx, 1'b0} +: 2] = add_s;
    end

    // Adder drives come only from registered state and operands.
    assign add_a   = (state == S_SLICE) ? op_a[{idx, 1'b0} +: 2] : 2'b00;
    assign add_b   = (state == S_SLICE) ? op_b[{idx, 1'b0} +: 2] : 2'b00;
    assign add_cin = (state == S_SLICE) & carry;
    assign busy    = (state == S_SLICE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees pre-edge values of the others.
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        acc   <= '0;
                        idx   <= '0;
                        cnt   <= '0;
                        state <= S_SLICE;
                    end
                end
                S_SLICE: begin
                    if (last_cnt) begin
                        cnt   <= '0;
                        acc   <= acc_next;
                        carry <= add_cout;
                        if (last_idx) begin
                            sum   <= acc_next;
                            cout  <= add_cout;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
